// File: rtl/pixel_transform_pkg.sv
// Shared encodings for the per-pixel colour transform: modes, FSM states and
// the default grayscale weights (Q0.8, summing to 256).
package pixel_transform_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'b00,
      MODE_GRAY   = 2'b01,
      MODE_INV    = 2'b10,
      MODE_BRIGHT = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACC0 = 3'd1,
      ST_ACC1 = 3'd2,
      ST_ACC2 = 3'd3,
      ST_NORM = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   localparam logic [7:0] COEF_R_DEF = 8'd77;
   localparam logic [7:0] COEF_G_DEF = 8'd150;
   localparam logic [7:0] COEF_B_DEF = 8'd29;

   function automatic logic is_busy_state(input state_e s);
      return (s == ST_ACC0) || (s == ST_ACC1) || (s == ST_ACC2) || (s == ST_NORM);
   endfunction

endpackage

// File: rtl/pixel_transform_if.sv
// Pixel bundle between the RGB assembler / TX sequencer side (master) and the
// transform block (slave).
interface pixel_transform_if;
   import pixel_transform_pkg::*;

   logic       enable;
   mode_e      mode;
   logic [7:0] brightness;
   logic [7:0] old_red;
   logic [7:0] old_green;
   logic [7:0] old_blue;
   logic [7:0] new_red;
   logic [7:0] new_green;
   logic [7:0] new_blue;
   logic       done;
   logic       busy;
   logic       overrun;

   modport master (
      output enable, mode, brightness, old_red, old_green, old_blue,
      input  new_red, new_green, new_blue, done, busy, overrun
   );

   modport slave (
      input  enable, mode, brightness, old_red, old_green, old_blue,
      output new_red, new_green, new_blue, done, busy, overrun
   );

endinterface

// File: rtl/pixel_transform_sat_add_u8.sv
// Unsigned 8-bit channel plus signed 8-bit offset, clamped to 0..255.
module sat_add_u8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o
);

   logic signed [9:0] sum_s;

   assign sum_s = $signed({2'b00, a_i}) + $signed({{2{b_i[7]}}, b_i});

   // sum_s[9] flags a negative result, sum_s[8] an overshoot past 255
   always_comb begin
      y_o = sum_s[7:0];
      if (sum_s[9]) begin
         y_o = 8'd0;
      end else if (sum_s[8]) begin
         y_o = 8'd255;
      end else begin
         y_o = sum_s[7:0];
      end
   end

endmodule

// File: rtl/pixel_transform.sv
// Captures one RGB888 pixel, accumulates the weighted luma over three cycles
// with one shared multiplier, then applies the selected colour transform.
module pixel_transform
   import pixel_transform_pkg::*;
#(
   parameter logic [7:0] COEF_R = COEF_R_DEF,
   parameter logic [7:0] COEF_G = COEF_G_DEF,
   parameter logic [7:0] COEF_B = COEF_B_DEF
) (
   input  logic                clk,
   input  logic                reset,
   pixel_transform_if.slave    pix
);

   state_e     state_q, state_d;
   mode_e      mode_q, mode_d;
   logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [7:0] bright_q, bright_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0] new_r_q, new_r_d, new_g_q, new_g_d, new_b_q, new_b_d;
   logic       done_q, done_d, busy_q, busy_d, overrun_q, overrun_d;

   logic [7:0]  chan_s, coef_s;
   logic [15:0] prod_s;
   logic [7:0]  sat_r_s, sat_g_s, sat_b_s;

   sat_add_u8 u_sat_r (.a_i(red_q),   .b_i(bright_q), .y_o(sat_r_s));
   sat_add_u8 u_sat_g (.a_i(green_q), .b_i(bright_q), .y_o(sat_g_s));
   sat_add_u8 u_sat_b (.a_i(blue_q),  .b_i(bright_q), .y_o(sat_b_s));

   assign prod_s = {8'd0, coef_s} * {8'd0, chan_s};

   // state and datapath registers; reset aborts any transform in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_PASS;
         red_q     <= 8'd0;
         green_q   <= 8'd0;
         blue_q    <= 8'd0;
         bright_q  <= 8'd0;
         acc_q     <= 16'd0;
         new_r_q   <= 8'd0;
         new_g_q   <= 8'd0;
         new_b_q   <= 8'd0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         red_q     <= red_d;
         green_q   <= green_d;
         blue_q    <= blue_d;
         bright_q  <= bright_d;
         acc_q     <= acc_d;
         new_r_q   <= new_r_d;
         new_g_q   <= new_g_d;
         new_b_q   <= new_b_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   // shared MAC operand select: one channel/weight pair per ACC state
   always_comb begin
      chan_s = 8'd0;
      coef_s = 8'd0;
      case (state_q)
         ST_ACC0: begin chan_s = red_q;   coef_s = COEF_R; end
         ST_ACC1: begin chan_s = green_q; coef_s = COEF_G; end
         ST_ACC2: begin chan_s = blue_q;  coef_s = COEF_B; end
         default: begin chan_s = 8'd0;    coef_s = 8'd0;   end
      endcase
   end

   // next-state and output computation
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      red_d     = red_q;
      green_d   = green_q;
      blue_d    = blue_q;
      bright_d  = bright_q;
      acc_d     = acc_q;
      new_r_d   = new_r_q;
      new_g_d   = new_g_q;
      new_b_d   = new_b_q;
      done_d    = done_q;
      busy_d    = busy_q;
      overrun_d = overrun_q;

      if (pix.enable && is_busy_state(state_q)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (pix.enable) begin
               red_d    = pix.old_red;
               green_d  = pix.old_green;
               blue_d   = pix.old_blue;
               mode_d   = pix.mode;
               bright_d = pix.brightness;
               acc_d    = 16'd0;
               done_d   = 1'b0;
               busy_d   = 1'b1;
               state_d  = ST_ACC0;
            end else begin
               state_d  = state_q;
            end
         end
         ST_ACC0: begin acc_d = acc_q + prod_s; state_d = ST_ACC1; end
         ST_ACC1: begin acc_d = acc_q + prod_s; state_d = ST_ACC2; end
         ST_ACC2: begin acc_d = acc_q + prod_s; state_d = ST_NORM; end
         ST_NORM: begin
            case (mode_q)
               MODE_PASS: begin
                  new_r_d = red_q;   new_g_d = green_q;   new_b_d = blue_q;
               end
               MODE_GRAY: begin
                  new_r_d = acc_q[15:8]; new_g_d = acc_q[15:8]; new_b_d = acc_q[15:8];
               end
               MODE_INV: begin
                  new_r_d = 8'd255 - red_q;
                  new_g_d = 8'd255 - green_q;
                  new_b_d = 8'd255 - blue_q;
               end
               MODE_BRIGHT: begin
                  new_r_d = sat_r_s; new_g_d = sat_g_s; new_b_d = sat_b_s;
               end
               default: begin
                  new_r_d = red_q;   new_g_d = green_q;   new_b_d = blue_q;
               end
            endcase
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   assign pix.new_red   = new_r_q;
   assign pix.new_green = new_g_q;
   assign pix.new_blue  = new_b_q;
   assign pix.done      = done_q;
   assign pix.busy      = busy_q;
   assign pix.overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_transform.sv
// Directed bench for pixel_transform: hand-computed colour results, latency,
// overrun stickiness, mid-transform reset and back-to-back restart.
module tb_pixel_transform;
   import pixel_transform_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [7:0] prev_r, prev_g, prev_b;

   pixel_transform_if pix();

   pixel_transform dut (
      .clk   (clk),
      .reset (reset),
      .pix   (pix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                            input logic [7:0] eb);
      check_val({tag, ".r"}, {24'd0, pix.new_red},   {24'd0, er});
      check_val({tag, ".g"}, {24'd0, pix.new_green}, {24'd0, eg});
      check_val({tag, ".b"}, {24'd0, pix.new_blue},  {24'd0, eb});
   endtask

   task automatic drive_pixel(input mode_e m, input logic [7:0] br, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b);
      pix.enable     = 1'b1;
      pix.mode       = m;
      pix.brightness = br;
      pix.old_red    = r;
      pix.old_green  = g;
      pix.old_blue   = b;
   endtask

   // One full transform: prior result must hold while busy, done rises exactly
   // five clocks after enable is presented.
   task automatic run_pixel(input string tag, input mode_e m, input logic [7:0] br,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
      @(negedge clk);
      drive_pixel(m, br, r, g, b);
      @(negedge clk);
      pix.enable = 1'b0;
      check_val({tag, ".busy_acc0"}, {31'd0, pix.busy}, 32'd1);
      check_val({tag, ".done_acc0"}, {31'd0, pix.done}, 32'd0);
      repeat (3) @(negedge clk);
      check_val({tag, ".done_norm"}, {31'd0, pix.done}, 32'd0);
      check_rgb({tag, ".held"}, prev_r, prev_g, prev_b);
      @(negedge clk);
      check_val({tag, ".done"}, {31'd0, pix.done}, 32'd1);
      check_val({tag, ".busy"}, {31'd0, pix.busy}, 32'd0);
      check_rgb(tag, er, eg, eb);
      prev_r = er;
      prev_g = eg;
      prev_b = eb;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      prev_r = 8'd0;
      prev_g = 8'd0;
      prev_b = 8'd0;
      reset = 1'b0;
      drive_pixel(MODE_GRAY, 8'd0, 8'd9, 8'd9, 8'd9);

      // enable asserted during reset must not start a transform
      repeat (3) @(negedge clk);
      pix.enable = 1'b0;
      reset = 1'b1;
      check_val("rst.done",    {31'd0, pix.done},    32'd0);
      check_val("rst.busy",    {31'd0, pix.busy},    32'd0);
      check_val("rst.overrun", {31'd0, pix.overrun}, 32'd0);
      check_rgb("rst", 8'd0, 8'd0, 8'd0);
      @(negedge clk);
      check_val("rst.idle_busy", {31'd0, pix.busy}, 32'd0);

      run_pixel("gray1", MODE_GRAY, 8'd0, 8'd100, 8'd50, 8'd200, 8'd82, 8'd82, 8'd82);
      @(negedge clk);
      check_val("gray1.hold_done", {31'd0, pix.done}, 32'd1);
      run_pixel("gray2", MODE_GRAY, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
      run_pixel("inv",   MODE_INV,  8'd0, 8'd0, 8'd128, 8'd255, 8'd255, 8'd127, 8'd0);
      run_pixel("pass",  MODE_PASS, 8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
      run_pixel("brt_pos", MODE_BRIGHT, 8'h28, 8'd250, 8'd10, 8'd100, 8'd255, 8'd50, 8'd140);
      run_pixel("brt_neg", MODE_BRIGHT, 8'hEC, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0);
      check_val("pre_ovr.overrun", {31'd0, pix.overrun}, 32'd0);

      // second enable lands in ACC1; the first pixel's result must survive
      @(negedge clk);
      drive_pixel(MODE_PASS, 8'd0, 8'd7, 8'd8, 8'd9);
      @(negedge clk);
      pix.enable = 1'b0;
      @(negedge clk);
      drive_pixel(MODE_INV, 8'd0, 8'd200, 8'd200, 8'd200);
      @(negedge clk);
      pix.enable = 1'b0;
      check_val("ovr.overrun_set", {31'd0, pix.overrun}, 32'd1);
      repeat (2) @(negedge clk);
      check_val("ovr.done", {31'd0, pix.done}, 32'd1);
      check_rgb("ovr", 8'd7, 8'd8, 8'd9);
      prev_r = 8'd7;
      prev_g = 8'd8;
      prev_b = 8'd9;
      run_pixel("ovr_next", MODE_INV, 8'd0, 8'd10, 8'd20, 8'd30, 8'd245, 8'd235, 8'd225);
      check_val("ovr.sticky", {31'd0, pix.overrun}, 32'd1);

      // reset while in ACC2 aborts the transform and clears everything
      @(negedge clk);
      drive_pixel(MODE_GRAY, 8'd0, 8'd100, 8'd50, 8'd200);
      @(negedge clk);
      pix.enable = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_val("abort.done",    {31'd0, pix.done},    32'd0);
      check_val("abort.busy",    {31'd0, pix.busy},    32'd0);
      check_val("abort.overrun", {31'd0, pix.overrun}, 32'd0);
      check_rgb("abort", 8'd0, 8'd0, 8'd0);
      prev_r = 8'd0;
      prev_g = 8'd0;
      prev_b = 8'd0;
      repeat (4) @(negedge clk);
      check_val("abort.no_done", {31'd0, pix.done}, 32'd0);
      run_pixel("post_rst", MODE_PASS, 8'd0, 8'd5, 8'd6, 8'd7, 8'd5, 8'd6, 8'd7);

      // restart straight from DONE; done must drop the next cycle
      run_pixel("b2b", MODE_PASS, 8'd0, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30);
      check_val("b2b.overrun", {31'd0, pix.overrun}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
